// File: rtl/alu_issue.sv
// RV32I OP/OP-IMM issue stage: decode, register file read, pending-destination scoreboard
// and a one-entry output register feeding the ALU. Define ALU_ISSUE_BYPASS_EN for writeback forwarding.
module alu_issue #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] REG_INIT = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ra_d,
    output logic [XLEN-1:0] rb_d,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic            imm_t,
    output logic [4:0]      out_rd,
    output logic            illegal,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data
);
    // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
    // ready never depends on valid, and the output side holds steady while valid & !ready.
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       is_op, is_opimm, legal;

    assign opcode   = in_instr[6:0];
    assign rd       = in_instr[11:7];
    assign f3       = in_instr[14:12];
    assign rs1      = in_instr[19:15];
    assign rs2      = in_instr[24:20];
    assign f7       = in_instr[31:25];
    assign is_op    = (opcode == OPC_OP);
    assign is_opimm = (opcode == OPC_OPIMM);

    always_comb begin
        legal = 1'b0;
        if (is_op) begin
            legal = (f7 == 7'b0000000) ||
                    ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
        end else if (is_opimm) begin
            case (f3)
                3'b001:  legal = (f7 == 7'b0000000);
                3'b101:  legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                default: legal = 1'b1;
            endcase
        end
    end

    logic [XLEN-1:0] rf_q [32];
    logic [31:0]     pend_q, pend_d, wb_clr, pend_haz;
    logic            hazard, slot_free, accept, issue;
    logic [XLEN-1:0] rs1_val, rs2_val, imm_ext;

    // x0 is never written and never marked pending, so it needs no special-casing on reads.
    assign wb_clr = (wb_valid && (wb_rd != 5'd0)) ? (32'd1 << wb_rd) : 32'd0;

`ifdef ALU_ISSUE_BYPASS_EN
    assign pend_haz = pend_q & ~wb_clr;
`else
    assign pend_haz = pend_q;
`endif

    assign hazard    = pend_haz[rs1] | (is_op & pend_haz[rs2]) | pend_haz[rd];
    assign slot_free = !out_valid | out_ready;
    assign in_ready  = slot_free & !hazard;
    assign accept    = in_valid & in_ready;
    assign issue     = accept & legal;
    assign imm_ext   = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};

    always_comb begin
        rs1_val = rf_q[rs1];
        rs2_val = rf_q[rs2];
`ifdef ALU_ISSUE_BYPASS_EN
        if (wb_valid && (wb_rd != 5'd0) && (wb_rd == rs1)) rs1_val = wb_data;
        if (wb_valid && (wb_rd != 5'd0) && (wb_rd == rs2)) rs2_val = wb_data;
`endif
    end

    // An issue to the same rd as this cycle's writeback re-arms the bit: set wins over clear.
    always_comb begin
        pend_d = pend_q & ~wb_clr;
        if (issue && (rd != 5'd0)) pend_d[rd] = 1'b1;
    end

    logic            out_valid_q, out_valid_d, illegal_q, illegal_d;
    logic [XLEN-1:0] ra_q, rb_q;
    logic [2:0]      f3_q;
    logic [6:0]      f7_q;
    logic            imm_q;
    logic [4:0]      rd_q;

    always_comb begin
        out_valid_d = out_valid_q & !out_ready;
        if (issue) out_valid_d = 1'b1;
        illegal_d = accept & !legal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= (i == 0) ? '0 : REG_INIT;
        end else if (wb_valid && (wb_rd != 5'd0)) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            ra_q        <= '0;
            rb_q        <= '0;
            f3_q        <= '0;
            f7_q        <= '0;
            imm_q       <= 1'b0;
            rd_q        <= '0;
        end else begin
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            if (issue) begin
                ra_q  <= rs1_val;
                rb_q  <= is_op ? rs2_val : imm_ext;
                f3_q  <= f3;
                f7_q  <= f7;
                imm_q <= is_opimm;
                rd_q  <= rd;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign illegal   = illegal_q;
    assign ra_d      = ra_q;
    assign rb_d      = rb_q;
    assign func3     = f3_q;
    assign func7     = f7_q;
    assign imm_t     = imm_q;
    assign out_rd    = rd_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios followed by randomized traffic against a
// reference model of register file, pending set and output slot.
module tb_alu_issue;
    logic        clk, rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, ra_d, rb_d, wb_data;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        imm_t, illegal, wb_valid;
    logic [4:0]  out_rd, wb_rd;

    int n_assert = 0;
    int n_fail   = 0;

    logic [79:0] exp_q[$];
    logic [31:0] m_rf [32];
    bit          m_pend [32];
    bit          m_ov, m_ill;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .ra_d(ra_d), .rb_d(rb_d), .func3(func3), .func7(func7), .imm_t(imm_t),
        .out_rd(out_rd), .illegal(illegal),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // driver tasks
    task automatic drive(input logic v, input logic [31:0] ins, input logic ordy);
        in_valid  = v;
        in_instr  = ins;
        out_ready = ordy;
    endtask

    task automatic drive_wb(input logic v, input logic [4:0] r, input logic [31:0] d);
        wb_valid = v;
        wb_rd    = r;
        wb_data  = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 1'b0);
        drive_wb(1'b0, 5'd0, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // scoreboard helpers
    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] mk(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] f3, input logic [6:0] f7,
                                       input logic imm, input logic [4:0] rd);
        return {a, b, f3, f7, imm, rd};
    endfunction

    function automatic logic [79:0] obs_out();
        return {ra_d, rb_d, func3, func7, imm_t, out_rd};
    endfunction

    function automatic logic [79:0] b1(input logic x);
        return {79'd0, x};
    endfunction

    // reference model: instruction legality from the ISA subset rules
    function automatic bit m_legal(input logic [31:0] i);
        logic [6:0] f7 = i[31:25];
        logic [2:0] f3 = i[14:12];
        if (i[6:0] == 7'b0110011)
            return (f7 == 7'd0) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        if (i[6:0] == 7'b0010011) begin
            if (f3 == 3'd1) return f7 == 7'd0;
            if (f3 == 3'd5) return f7 == 7'd0 || f7 == 7'h20;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
`ifdef ALU_ISSUE_BYPASS_EN
        if (wb_valid && wb_rd == r) return wb_data;
`endif
        return m_rf[r];
    endfunction

    function automatic logic [31:0] gen_instr();
        int         k   = $urandom_range(0, 9);
        logic [4:0] rd  = 5'($urandom_range(0, 7));
        logic [4:0] rs1 = 5'($urandom_range(0, 7));
        logic [4:0] rs2 = 5'($urandom_range(0, 7));
        logic [2:0] f3  = 3'($urandom_range(0, 7));
        logic [11:0] imm = 12'($urandom);
        logic [6:0] f7;
        if (k <= 3) begin
            f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            return {f7, rs2, rs1, f3, rd, 7'b0110011};
        end
        if (k <= 7) begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
                case ($urandom_range(0, 2))
                    0: imm[11:5] = 7'h00;
                    1: imm[11:5] = 7'h20;
                    default: ;
                endcase
            end
            return {imm, rs1, f3, rd, 7'b0010011};
        end
        if (k == 8) return $urandom;
        f7 = 7'($urandom);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    initial begin
        logic [31:0] ins;
        bit          pv [32];
        bit          exp_ready, is_op, acc, lg;
        logic [31:0] a, b;
        int          cand[$];

        do_reset();

        // reset state
        check("rst_out_valid", b1(out_valid), b1(1'b0));
        check("rst_illegal", b1(illegal), b1(1'b0));
        check("rst_outputs", obs_out(), 80'd0);
        mid();
        check("rst_in_ready", b1(in_ready), b1(1'b1));
        tick();

        // ADDI x1,x0,-5
        drive(1'b1, 32'hFFB00093, 1'b1);
        mid();
        check("addi_in_ready", b1(in_ready), b1(1'b1));
        tick();
        check("addi_out_valid", b1(out_valid), b1(1'b1));
        check("addi_outputs", obs_out(), mk(32'd0, 32'hFFFFFFFB, 3'd0, 7'h7F, 1'b1, 5'd1));

        // ADD x5,x1,x1 waits on x1
        drive(1'b1, 32'h001082B3, 1'b1);
        mid();
        check("raw_stall_0", b1(in_ready), b1(1'b0));
        tick();
        check("raw_drain_valid", b1(out_valid), b1(1'b0));
        mid();
        check("raw_stall_1", b1(in_ready), b1(1'b0));
        tick();
        drive_wb(1'b1, 5'd1, 32'h10);
        mid();
`ifdef ALU_ISSUE_BYPASS_EN
        check("raw_wb_ready", b1(in_ready), b1(1'b1));
        tick();
        drive_wb(1'b0, 5'd0, 32'd0);
`else
        check("raw_wb_ready", b1(in_ready), b1(1'b0));
        tick();
        drive_wb(1'b0, 5'd0, 32'd0);
        mid();
        check("raw_after_wb_ready", b1(in_ready), b1(1'b1));
        tick();
`endif
        check("raw_out_valid", b1(out_valid), b1(1'b1));
        check("raw_outputs", obs_out(), mk(32'h10, 32'h10, 3'd0, 7'd0, 1'b0, 5'd5));
        drive(1'b0, 32'd0, 1'b1);

        // x2=7, x3=9, then SUB x4,x2,x3
        drive_wb(1'b1, 5'd2, 32'd7);
        tick();
        drive_wb(1'b1, 5'd3, 32'd9);
        tick();
        drive_wb(1'b0, 5'd0, 32'd0);
        drive(1'b1, 32'h40310233, 1'b1);
        mid();
        check("sub_in_ready", b1(in_ready), b1(1'b1));
        tick();
        check("sub_outputs", obs_out(), mk(32'd7, 32'd9, 3'd0, 7'h20, 1'b0, 5'd4));

        // back-pressure: ADD x6 held while ADDI x7 waits
        drive(1'b1, 32'h00310333, 1'b1);
        tick();
        check("add6_outputs", obs_out(), mk(32'd7, 32'd9, 3'd0, 7'd0, 1'b0, 5'd6));
        drive(1'b1, 32'h00110393, 1'b0);
        for (int i = 0; i < 3; i++) begin
            mid();
            check("hold_in_ready", b1(in_ready), b1(1'b0));
            tick();
            check("hold_out_valid", b1(out_valid), b1(1'b1));
            check("hold_outputs", obs_out(), mk(32'd7, 32'd9, 3'd0, 7'd0, 1'b0, 5'd6));
        end
        out_ready = 1'b1;
        mid();
        check("release_in_ready", b1(in_ready), b1(1'b1));
        tick();
        check("release_outputs", obs_out(), mk(32'd7, 32'd1, 3'd0, 7'd0, 1'b1, 5'd7));

        // illegal instructions
        drive(1'b1, 32'h00002083, 1'b1);
        mid();
        check("lw_in_ready", b1(in_ready), b1(1'b1));
        tick();
        check("lw_illegal", b1(illegal), b1(1'b1));
        check("lw_out_valid", b1(out_valid), b1(1'b0));
        drive(1'b0, 32'd0, 1'b1);
        tick();
        check("lw_illegal_pulse", b1(illegal), b1(1'b0));
        drive(1'b1, 32'h40101093, 1'b1);
        tick();
        check("slli_illegal", b1(illegal), b1(1'b1));
        check("slli_out_valid", b1(out_valid), b1(1'b0));
        drive(1'b0, 32'd0, 1'b1);
        tick();

        // reset mid-stream with x1 pending and output held
        drive(1'b1, 32'hFFB00093, 1'b0);
        tick();
        check("pre_rst_out_valid", b1(out_valid), b1(1'b1));
        drive(1'b1, 32'h001082B3, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", b1(out_valid), b1(1'b0));
        check("midrst_in_ready", b1(in_ready), b1(1'b1));
        drive(1'b0, 32'd0, 1'b1);
        tick();
        rst_n = 1'b1;
        drive_wb(1'b1, 5'd0, 32'hDEAD);
        tick();
        drive_wb(1'b0, 5'd0, 32'd0);
        drive(1'b1, 32'h00008433, 1'b1);
        tick();
        check("x0_x1_after_rst", obs_out(), mk(32'd0, 32'd0, 3'd0, 7'd0, 1'b0, 5'd8));
        drive(1'b0, 32'd0, 1'b1);

        // randomized traffic against the model
        do_reset();
        for (int i = 0; i < 32; i++) begin
            m_rf[i]   = 32'd0;
            m_pend[i] = 1'b0;
        end
        m_ov  = 1'b0;
        m_ill = 1'b0;
        exp_q.delete();

        for (int c = 0; c < 800; c++) begin
            check("rnd_out_valid", b1(out_valid), b1(m_ov));
            check("rnd_illegal", b1(illegal), b1(m_ill));
            if (m_ov) check("rnd_outputs", obs_out(), exp_q[0]);

            ins = gen_instr();
            drive(($urandom_range(0, 3) != 0), ins, ($urandom_range(0, 3) != 0));
            cand.delete();
            for (int r = 1; r < 32; r++) if (m_pend[r]) cand.push_back(r);
            if (cand.size() > 0 && $urandom_range(0, 3) != 0)
                drive_wb(($urandom_range(0, 1) == 1), 5'(cand[$urandom_range(0, cand.size() - 1)]), $urandom);
            else
                drive_wb(($urandom_range(0, 5) == 0), 5'($urandom_range(0, 7)), $urandom);

            mid();
            for (int r = 0; r < 32; r++) pv[r] = m_pend[r];
`ifdef ALU_ISSUE_BYPASS_EN
            if (wb_valid) pv[wb_rd] = 1'b0;
`endif
            is_op = (ins[6:0] == 7'b0110011);
            exp_ready = !(m_ov && !out_ready) &&
                        !(pv[ins[19:15]] || (is_op && pv[ins[24:20]]) || pv[ins[11:7]]);
            check("rnd_in_ready", b1(in_ready), b1(exp_ready));

            acc = in_valid && exp_ready;
            lg  = m_legal(ins);
            if (m_ov && out_ready) begin
                void'(exp_q.pop_front());
                m_ov = 1'b0;
            end
            if (acc && lg) begin
                a = m_read(ins[19:15]);
                b = is_op ? m_read(ins[24:20]) : {{20{ins[31]}}, ins[31:20]};
                exp_q.push_back(mk(a, b, ins[14:12], ins[31:25], !is_op, ins[11:7]));
                m_ov = 1'b1;
            end
            m_ill = acc && !lg;
            if (wb_valid) begin
                if (wb_rd != 5'd0) m_rf[wb_rd] = wb_data;
                m_pend[wb_rd] = 1'b0;
            end
            if (acc && lg && ins[11:7] != 5'd0) m_pend[ins[11:7]] = 1'b1;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
